// File: rtl/comet_pkg.sv
// Shared definitions for the program memory: controller state encoding and the
// word written by the initialisation sweep.
package comet_pkg;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } pm_state_e;

  localparam logic [15:0] NOP_WORD = 16'h0000;

endpackage

// File: rtl/mem_array_1r1w.sv
// Simple dual-port storage: one synchronous read port, one write port.
// The read register is not reset, so the array stays block-RAM inferable.
module mem_array_1r1w #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              mclk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  // Non-blocking write and read on the same edge gives read-first behaviour.
  always_ff @(posedge mclk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/program_memory.sv
// Program memory controller: clears the array after reset, then serves
// range-checked, write-protectable reads and writes with one-cycle read latency.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ST_INIT | sweeping NOP into every word; requests ignored, ready=0
// ST_RUN  | normal operation; reads/writes checked, faults reported
module program_memory
  import comet_pkg::*;
#(
  parameter int          ADDR_W   = 8,
  parameter int          DATA_W   = 16,
  parameter logic [15:0] WP_LIMIT = 16'h005F
) (
  input  logic              mclk,
  input  logic              rst,
  input  logic              we,
  input  logic [15:0]       waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [15:0]       raddr,
  input  logic              wp_en,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              ready,
  output logic              rd_fault,
  output logic              wr_fault
);

  localparam logic [16:0]       DEPTH_W  = 17'(2 ** ADDR_W);
  localparam logic [ADDR_W-1:0] PTR_LAST = '1;

  pm_state_e         state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              rvalid_q, rd_fault_q, wr_fault_q;
  logic              rd_ok, rd_bad, wr_bad;
  logic              rd_in_range, wr_in_range, wr_prot;
  logic              mem_we, mem_re;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;

  // Range checks use all 16 address bits so out-of-range accesses never alias.
  assign rd_in_range = ({1'b0, raddr} < DEPTH_W);
  assign wr_in_range = ({1'b0, waddr} < DEPTH_W);
  assign wr_prot     = wp_en && (waddr <= WP_LIMIT);

  always_ff @(posedge mclk) begin
    if (rst) begin
      state_q    <= ST_INIT;
      ptr_q      <= '0;
      rvalid_q   <= 1'b0;
      rd_fault_q <= 1'b0;
      wr_fault_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      rvalid_q   <= rd_ok;
      rd_fault_q <= rd_bad;
      wr_fault_q <= wr_bad;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    mem_we    = 1'b0;
    mem_re    = 1'b0;
    mem_waddr = waddr[ADDR_W-1:0];
    mem_wdata = wdata;
    rd_ok     = 1'b0;
    rd_bad    = 1'b0;
    wr_bad    = 1'b0;
    case (state_q)
      ST_INIT: begin
        mem_we    = 1'b1;
        mem_waddr = ptr_q;
        mem_wdata = DATA_W'(NOP_WORD);
        ptr_d     = ptr_q + 1'b1;
        if (ptr_q == PTR_LAST) state_d = ST_RUN;
      end
      ST_RUN: begin
        rd_ok  = re && rd_in_range;
        rd_bad = re && !rd_in_range;
        mem_re = rd_ok;
        mem_we = we && wr_in_range && !wr_prot;
        wr_bad = we && !(wr_in_range && !wr_prot);
      end
      default: state_d = ST_INIT;
    endcase
  end

  mem_array_1r1w #(
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W)
  ) u_mem (
    .mclk (mclk),
    .we   (mem_we && !rst),
    .waddr(mem_waddr),
    .wdata(mem_wdata),
    .re   (mem_re && !rst),
    .raddr(raddr[ADDR_W-1:0]),
    .rdata(mem_rdata)
  );

  // The RAM output register is unreset; mask it so rdata is 0 whenever invalid.
  assign rdata    = rvalid_q ? mem_rdata : '0;
  assign rvalid   = rvalid_q;
  assign ready    = (state_q == ST_RUN);
  assign rd_fault = rd_fault_q;
  assign wr_fault = wr_fault_q;

endmodule

// File: tb/tb_program_memory.sv
// Randomised and directed checks of program_memory against an array-based
// reference model of the sweep, range, protection and read-first rules.
module tb_program_memory;

  localparam int          ADDR_W   = 8;
  localparam int          DATA_W   = 16;
  localparam int          DEPTH    = 256;
  localparam logic [15:0] WP_LIMIT = 16'h005F;

  logic              mclk = 1'b0;
  logic              rst, we, re, wp_en;
  logic [15:0]       waddr, raddr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              rvalid, ready, rd_fault, wr_fault;

  always #5 mclk = ~mclk;

  program_memory #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .WP_LIMIT(WP_LIMIT)
  ) dut (
    .mclk    (mclk),
    .rst     (rst),
    .we      (we),
    .waddr   (waddr),
    .wdata   (wdata),
    .re      (re),
    .raddr   (raddr),
    .wp_en   (wp_en),
    .rdata   (rdata),
    .rvalid  (rvalid),
    .ready   (ready),
    .rd_fault(rd_fault),
    .wr_fault(wr_fault)
  );

  int n_vec  = 0;
  int n_miss = 0;
  int n_cyc  = 0;

  logic [15:0] ref_mem [DEPTH];
  int          sweep_done = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, n_cyc, got, exp);
    end
  endtask

  // One clock: drive inputs, predict the outputs after the edge, then compare.
  task automatic cycle(input logic r, input logic [15:0] ra, input logic w,
                       input logic [15:0] wa, input logic [15:0] wd,
                       input logic wp, input logic rs);
    logic        e_rv, e_rf, e_wf;
    logic [15:0] e_rd;
    e_rv = 1'b0; e_rf = 1'b0; e_wf = 1'b0; e_rd = 16'h0000;
    rst = rs; re = r; raddr = ra; we = w; waddr = wa; wdata = wd; wp_en = wp;
    if (rs) begin
      sweep_done = 0;
    end else if (sweep_done < DEPTH) begin
      sweep_done++;
      if (sweep_done == DEPTH)
        foreach (ref_mem[i]) ref_mem[i] = 16'h0000;
    end else begin
      if (r) begin
        if (int'(ra) < DEPTH) begin
          e_rv = 1'b1;
          e_rd = ref_mem[int'(ra)];
        end else begin
          e_rf = 1'b1;
        end
      end
      if (w) begin
        if (int'(wa) < DEPTH && !(wp && wa <= WP_LIMIT)) ref_mem[int'(wa)] = wd;
        else e_wf = 1'b1;
      end
    end
    @(posedge mclk);
    #1;
    n_cyc++;
    chk("rvalid",   32'(rvalid),   32'(e_rv));
    chk("rdata",    32'(rdata),    32'(e_rd));
    chk("rd_fault", 32'(rd_fault), 32'(e_rf));
    chk("wr_fault", 32'(wr_fault), 32'(e_wf));
    chk("ready",    32'(ready),    32'(sweep_done >= DEPTH));
  endtask

  task automatic rd(input logic [15:0] a);
    cycle(1'b1, a, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] d, input logic wp);
    cycle(1'b0, 16'h0, 1'b1, a, d, wp, 1'b0);
  endtask

  function automatic logic [15:0] rand_addr();
    int unsigned sel;
    sel = $urandom_range(0, 9);
    if (sel < 6)       return 16'($urandom_range(0, DEPTH - 1));
    else if (sel == 6) return 16'($urandom_range(16'h0050, 16'h006F));
    else if (sel == 7) return 16'($urandom_range(DEPTH, DEPTH + 15));
    else if (sel == 8) return 16'($urandom);
    else begin
      case ($urandom_range(0, 3))
        0:       return 16'h00FF;
        1:       return 16'h005F;
        2:       return 16'h0060;
        default: return 16'h0100;
      endcase
    end
  endfunction

  task automatic rand_cycle(input logic allow_rst);
    logic rs;
    rs = allow_rst && ($urandom_range(0, 99) == 0);
    cycle(1'($urandom), rand_addr(), 1'($urandom), rand_addr(), 16'($urandom),
          1'($urandom), rs);
  endtask

  task automatic sweep_cycles(input int n);
    for (int i = 0; i < n; i++) rand_cycle(1'b0);
  endtask

  initial begin
    rst = 1'b1; re = 1'b0; we = 1'b0; wp_en = 1'b0;
    raddr = '0; waddr = '0; wdata = '0;
    foreach (ref_mem[i]) ref_mem[i] = 16'hxxxx;

    cycle(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);

    // Sweep with random requests, which must all be ignored; then reads of zero.
    sweep_cycles(DEPTH);
    rd(16'h0000);
    rd(16'h00FF);
    for (int i = 0; i < 8; i++) rd(16'($urandom_range(0, DEPTH - 1)));

    wr(16'h0070, 16'h1234, 1'b0);
    rd(16'h0070);

    wr(16'h0010, 16'hABCD, 1'b1);
    rd(16'h0010);
    wr(16'h0010, 16'hABCD, 1'b0);
    rd(16'h0010);
    wr(16'h005F, 16'h5F5F, 1'b1);
    wr(16'h0060, 16'h6060, 1'b1);
    rd(16'h005F);
    rd(16'h0060);

    rd(16'h0100);
    rd(16'hFFFF);
    wr(16'h0100, 16'hDEAD, 1'b0);
    rd(16'h0000);

    wr(16'h0080, 16'h1111, 1'b0);
    cycle(1'b1, 16'h0080, 1'b1, 16'h0080, 16'h2222, 1'b0, 1'b0);
    rd(16'h0080);

    for (int i = 0; i < 400; i++) rand_cycle(1'b0);

    // Reset with a read in flight, then reset again partway through the sweep.
    rd(16'h0070);
    cycle(1'b1, 16'h0070, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    sweep_cycles(16'h0040);
    cycle(1'b0, 16'h0, 1'b0, 16'h0, 16'h0, 1'b0, 1'b1);
    sweep_cycles(DEPTH);
    rd(16'h0070);
    rd(16'h0080);
    rd(16'h0010);

    for (int i = 0; i < 600; i++) rand_cycle(1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/program_memory.md
PROGRAM_MEMORY -- requirements
Module: program_memory

Interface
REQ-001 Parameter ADDR_W, default 8, sets the number of implemented word-address bits; DEPTH = 2**ADDR_W words.
REQ-002 Parameter DATA_W, default 16, sets the word width.
REQ-003 Parameter WP_LIMIT, default 16'h005F, is the highest address protected from writes while wp_en=1.
REQ-004 mclk  input  1  sole clock; all state updates on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 we  input  1  write request, sampled each cycle.
REQ-007 waddr  input  16  write word address.
REQ-008 wdata  input  DATA_W  write data.
REQ-009 re  input  1  read request, sampled each cycle.
REQ-010 raddr  input  16  read word address.
REQ-011 wp_en  input  1  enables write protection of addresses 0..WP_LIMIT.
REQ-012 rdata  output  DATA_W  registered read data.
REQ-013 rvalid  output  1  rdata holds the result of the request accepted in the previous cycle.
REQ-014 ready  output  1  high once the initialisation sweep is complete.
REQ-015 rd_fault  output  1  one-cycle pulse for a rejected read.
REQ-016 wr_fault  output  1  one-cycle pulse for a rejected write.

Function
REQ-017 After reset, the block runs an INIT sweep that writes 0 (NOP) to addresses 0..DEPTH-1, one word per cycle; ready=0 throughout.
REQ-018 The FSM states are INIT and RUN; INIT->RUN follows the write to address DEPTH-1, so ready rises exactly DEPTH cycles after rst falls.
REQ-019 In INIT, re and we are ignored: no memory update, rvalid=0, and no fault pulses.
REQ-020 In RUN, a read with re=1 and raddr<DEPTH returns mem[raddr] on rdata with rvalid=1 in the next cycle (latency 1).
REQ-021 In RUN, a read with raddr>=DEPTH is rejected: the next cycle has rvalid=0, rd_fault=1 and rdata=0.
REQ-022 rdata is 0 whenever rvalid=0; it is never high-impedance.
REQ-023 In RUN, a write with we=1 updates mem[waddr] at the same rising edge when waddr<DEPTH and not (wp_en=1 and waddr<=WP_LIMIT).
REQ-024 A write with waddr>=DEPTH, or a protected write, leaves memory unchanged and pulses wr_fault in the next cycle.
REQ-025 A simultaneous read and write to the same address is read-first: rdata returns the old word, and the new word is visible from the next read.
REQ-026 Back-to-back reads are accepted every cycle, giving full throughput with no stall.
REQ-027 Only address bits [ADDR_W-1:0] index the array; the range check uses all 16 bits, so addresses never wrap silently.

Reset
REQ-028 When rst=1: FSM=INIT, sweep pointer=0, ready=0, rvalid=0, rdata=0, rd_fault=0, wr_fault=0.
REQ-029 Asserting rst mid-sweep or in RUN restarts the sweep from address 0 and discards any in-flight read result.
REQ-030 Reset does not clear memory directly; only the INIT sweep clears it.

Structure
REQ-031 The FSM state encoding (INIT, RUN) and the NOP word constant (16'h0000) belong in the shared package comet_pkg.
REQ-032 The storage array is a sub-module named mem_array_1r1w: one synchronous read port and one write port, inferable as block RAM.
REQ-033 The FSM, sweep counter, range and protection checks and fault logic live in program_memory.

Verification
REQ-034 Scenario 1 (ADDR_W=8): release rst -> ready rises after exactly 256 cycles; reading any address afterwards returns 0000h with rvalid=1.
REQ-035 Scenario 2: in RUN, write 1234h to 0070h, then read 0070h the next cycle -> rdata=1234h and rvalid=1 one cycle after the read.
REQ-036 Scenario 3: with wp_en=1, write ABCDh to 0010h -> wr_fault pulses for one cycle and a read of 0010h returns 0000h; repeat with wp_en=0 -> read returns ABCDh.
REQ-037 Scenario 4: read 0100h (ADDR_W=8) -> rd_fault=1, rvalid=0, rdata=0; write to 0100h -> wr_fault=1 and 0000h is unchanged (no wrap).
REQ-038 Scenario 5: with 0080h=1111h, same-cycle read and write of 2222h to 0080h -> rdata=1111h; the following read returns 2222h.
REQ-039 Scenario 6: assert rst at sweep address 0040h, and separately during a read -> sweep restarts with ready=0 for a further 256 cycles, and the in-flight read produces rvalid=0.
